mcs4_clk_ctrl: RTL

MCS4_CLK_CTRL -- requirements
Module: mcs4_clk_ctrl

---
 rtl/mcs4_clk_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mcs4_clk_ctrl.sv
// rtl/mcs4_clk_ctrl.sv - two-phase clock-enable generator with run/step/breakpoint control for a 4004 core
//
// Derives the 4004 phase-1/phase-2 clock enables from the system clock and
// decides when the CPU is allowed to run. The CPU can free-run, execute one
// instruction or stop at a breakpoint. It only stops on an instruction
// boundary (phase 2 of X3 with sync), so every started 4004 clock completes.
//
// Optional feature macro: MCS4_CLK_CTRL_BKPT_EN (instruction-address breakpoint).
//
// Ports:
//   clk          system clock, sole clock
//   rst          asynchronous active-high reset
//   run          level, 1 = free-run the CPU
//   step         single-cycle pulse, execute exactly one instruction
//   sync         CPU sync, marks end of X3
//   dbus[3:0]    observed data bus, used for breakpoint address capture
//   bkpt_en      breakpoint enable
//   bkpt_addr    breakpoint instruction address
//   clken_1      phase-1 clock enable to CPU/ROM/RAM
//   clken_2      phase-2 clock enable to CPU/ROM/RAM
//   running      1 whenever the controller is not halted
//   subcycle     0=A1 1=A2 2=A3 3=M1 4=M2 5=X1 6=X2 7=X3
//   sub_valid    subcycle has been aligned to an observed sync
//   instr_count  completed instructions, wraps
//   bkpt_hit     sticky breakpoint-halt flag
module mcs4_clk_ctrl #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  input  logic        sync,
  input  logic [3:0]  dbus,
  input  logic        bkpt_en,
  input  logic [11:0] bkpt_addr,
  output logic        clken_1,
  output logic        clken_2,
  output logic        running,
  output logic [2:0]  subcycle,
  output logic        sub_valid,
  output logic [15:0] instr_count,
  output logic        bkpt_hit
);

  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PH2  = DIV_W'(CLK_DIV);

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             boundary;
  logic             bkpt_pend;
  logic             stop_now;
  logic             leave_halt;

  // Instruction boundary: phase 2 of X3, flagged by the CPU's sync.
  assign boundary   = clken_2 & sync;
  assign stop_now   = boundary & ((state == STEP) | ~run | bkpt_pend);
  assign leave_halt = (state == HALT) & (run | step);

  // Run-control FSM. The enables are computed from the pre-increment
  // divider value, so clken_1 follows div_cnt==0 and clken_2 follows
  // div_cnt==CLK_DIV by one clk; both stay low while halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HALT;
      running <= 1'b0;
      div_cnt <= '0;
      clken_1 <= 1'b0;
      clken_2 <= 1'b0;
    end else begin
      case (state)
        HALT: begin
          div_cnt <= '0;
          clken_1 <= 1'b0;
          clken_2 <= 1'b0;
          if (run) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (step) begin
            state   <= STEP;
            running <= 1'b1;
          end
        end
        RUN, STEP: begin
          // step is deliberately not looked at here: pulses while
          // running or stepping have no effect.
          if (stop_now) begin
            state   <= HALT;
            running <= 1'b0;
            div_cnt <= '0;
            clken_1 <= 1'b0;
            clken_2 <= 1'b0;
          end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            clken_1 <= (div_cnt == '0);
            clken_2 <= (div_cnt == DIV_PH2);
          end
        end
        default: begin
          state   <= HALT;
          running <= 1'b0;
          div_cnt <= '0;
          clken_1 <= 1'b0;
          clken_2 <= 1'b0;
        end
      endcase
    end
  end

  // Subcycle tracker and instruction counter. A boundary re-aligns the
  // subcycle to A1 regardless of where the free count had drifted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      subcycle    <= 3'd0;
      sub_valid   <= 1'b0;
      instr_count <= 16'd0;
    end else if (boundary) begin
      subcycle    <= 3'd0;
      sub_valid   <= 1'b1;
      instr_count <= instr_count + 16'd1;
    end else if (clken_2) begin
      subcycle    <= subcycle + 3'd1;
    end
  end

`ifdef MCS4_CLK_CTRL_BKPT_EN
  logic [11:0] cap_addr;
  logic        cap_hi_unused;
  logic        bkpt_hit_q;

  // The high nibble is compared straight off the bus during A3, so the
  // registered copy of it is kept only for observation.
  assign cap_hi_unused = ^cap_addr[11:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_addr   <= 12'h000;
      bkpt_pend  <= 1'b0;
      bkpt_hit_q <= 1'b0;
    end else begin
      if (clken_2) begin
        case (subcycle)
          3'd0:    cap_addr[3:0]  <= dbus;
          3'd1:    cap_addr[7:4]  <= dbus;
          3'd2:    cap_addr[11:8] <= dbus;
          default: cap_addr       <= cap_addr;
        endcase
      end
      // Pending is only armed once the subcycle count is known to be
      // aligned, otherwise the nibbles could belong to different phases.
      if (boundary)
        bkpt_pend <= 1'b0;
      else if (clken_2 && (subcycle == 3'd2) && sub_valid && bkpt_en &&
               ({dbus, cap_addr[7:0]} == bkpt_addr))
        bkpt_pend <= 1'b1;
      if (leave_halt)
        bkpt_hit_q <= 1'b0;
      else if (boundary && bkpt_pend)
        bkpt_hit_q <= 1'b1;
    end
  end

  assign bkpt_hit = bkpt_hit_q;
`else
  logic bkpt_unused;
  logic leave_unused;

  assign bkpt_unused  = ^{bkpt_en, bkpt_addr, dbus};
  assign leave_unused = leave_halt;
  assign bkpt_pend    = 1'b0;
  assign bkpt_hit     = 1'b0;
`endif

endmodule
